// File: rtl/fetch_unit_buffered_if.sv
// Fetch unit bus: instruction-memory request/response, decode output and redirect.
// Carries o_misaligned only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_buffered_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req_valid;
  logic [XLEN-1:0] o_imem_req_addr;
  logic            i_imem_req_ready;
  logic            i_imem_rsp_valid;
  logic [ILEN-1:0] i_imem_rsp_data;
  logic            o_valid;
  logic [ILEN-1:0] o_instruction;
  logic [XLEN-1:0] o_pc;
  logic            i_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            o_misaligned;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    output o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction, o_pc, o_misaligned
  );
  modport slave (
    output i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    input  o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction, o_pc, o_misaligned
  );
`else
  modport master (
    input  i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    output o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction, o_pc
  );
  modport slave (
    output i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    input  o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction, o_pc
  );
`endif
endinterface

// File: rtl/fetch_unit_buffered.sv
// Buffered instruction fetch: sequential imem requests, in-order response FIFO, redirect drain.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets produce one trap entry instead of fetching.
module fetch_unit_buffered #(
  parameter int              XLEN            = 64,
  parameter int              ILEN            = 32,
  parameter int              BUF_DEPTH       = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  fetch_unit_buffered_if.master bus
);
  localparam int STEP = ILEN / 8;
  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW   = $clog2(BUF_DEPTH + 1);
  localparam int SW   = $clog2(BUF_DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0033);

  // FETCH: issue requests | DRAIN: discard stale responses | TRAP/IDLE: misaligned target
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP  = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd3;
`endif

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_out, r_drop;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_wp, r_rp, r_tag_wp, r_tag_rp;
  logic [XLEN-1:0] r_tag_pc   [BUF_DEPTH];
  logic [XLEN-1:0] r_fifo_pc  [BUF_DEPTH];
  logic [ILEN-1:0] r_fifo_ins [BUF_DEPTH];

  logic [XLEN-1:0] w_redirect_pc;
  logic [SW-1:0]   w_used;
  logic [OW-1:0]   w_out_next;
  logic            w_req_valid, w_req_fire, w_rsp_keep, w_push_rsp, w_push, w_pop;
  logic [XLEN-1:0] w_push_pc;
  logic [ILEN-1:0] w_push_ins;
  logic [1:0]      w_after_drain;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_misal_pend;
  logic [XLEN-1:0] r_trap_pc;
  logic            r_fifo_mis [BUF_DEPTH];
  logic            w_misal_tgt, w_push_trap;

  assign w_redirect_pc = bus.i_redirect_pc;
  assign w_misal_tgt   = |(bus.i_redirect_pc & XLEN'(STEP - 1));
  assign w_push_trap   = (r_state == S_TRAP) && !bus.i_redirect;
  assign w_push        = w_push_rsp || w_push_trap;
  assign w_push_pc     = w_push_trap ? r_trap_pc : r_tag_pc[r_tag_rp];
  assign w_push_ins    = w_push_trap ? NOP : bus.i_imem_rsp_data;
  assign w_after_drain = r_misal_pend ? S_TRAP : S_FETCH;
`else
  assign w_redirect_pc = bus.i_redirect_pc & ~XLEN'(STEP - 1);
  assign w_push        = w_push_rsp;
  assign w_push_pc     = r_tag_pc[r_tag_rp];
  assign w_push_ins    = bus.i_imem_rsp_data;
  assign w_after_drain = S_FETCH;
`endif

  assign w_used      = SW'(r_out) + SW'(r_cnt);
  assign w_req_valid = i_rst_n && (r_state == S_FETCH) && (r_out < OW'(MAX_OUTSTANDING))
                       && (w_used < SW'(BUF_DEPTH)) && !bus.i_redirect;
  assign w_req_fire  = w_req_valid && bus.i_imem_req_ready;
  assign w_rsp_keep  = bus.i_imem_rsp_valid && (r_drop == '0);
  assign w_push_rsp  = w_rsp_keep && !bus.i_redirect;
  assign w_pop       = (r_cnt != '0) && bus.i_ready && !bus.i_redirect;
  assign w_out_next  = r_out + OW'(w_req_fire) - OW'(bus.i_imem_rsp_valid);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misal_pend <= 1'b0;
      r_trap_pc    <= '0;
`endif
    end else begin
      r_out <= w_out_next;
      if (bus.i_redirect) begin
        // Everything still in flight after this edge is stale and gets dropped.
        r_fetch_pc <= w_redirect_pc;
        r_drop     <= w_out_next;
        r_cnt      <= '0;
        r_wp       <= '0;
        r_rp       <= '0;
        r_tag_wp   <= '0;
        r_tag_rp   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        r_misal_pend <= w_misal_tgt;
        r_trap_pc    <= bus.i_redirect_pc;
        if (w_out_next != '0) r_state <= S_DRAIN;
        else                  r_state <= w_misal_tgt ? S_TRAP : S_FETCH;
`else
        r_state <= (w_out_next != '0) ? S_DRAIN : S_FETCH;
`endif
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(STEP);
          r_tag_wp   <= r_tag_wp + AW'(1);
        end
        if (w_rsp_keep) r_tag_rp <= r_tag_rp + AW'(1);
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
        else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
        if (bus.i_imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - OW'(1);
          if (r_drop == OW'(1) && r_state == S_DRAIN) r_state <= w_after_drain;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (r_state == S_TRAP) r_state <= S_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_req_fire) r_tag_pc[r_tag_wp] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_pc[r_wp]  <= w_push_pc;
      r_fifo_ins[r_wp] <= w_push_ins;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fifo_mis[r_wp] <= w_push_trap;
`endif
    end
  end

  assign bus.o_imem_req_valid = w_req_valid;
  assign bus.o_imem_req_addr  = r_fetch_pc;
  assign bus.o_valid          = (r_cnt != '0);
  assign bus.o_pc             = bus.o_valid ? r_fifo_pc[r_rp] : '0;
  assign bus.o_instruction    = bus.o_valid ? r_fifo_ins[r_rp] : NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.o_misaligned     = bus.o_valid ? r_fifo_mis[r_rp] : 1'b0;
`endif

  // The issue credit keeps the FIFO from overflowing; a response into a full FIFO is a memory bug.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_push_rsp && !w_pop) |-> (r_cnt < CW'(BUF_DEPTH)));
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.i_imem_rsp_valid |-> (r_out != '0));
endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Scoreboard bench for fetch_unit_buffered: memory model with latency and accept budget,
// monitor pops expected {pc, instruction} entries whenever decode accepts an output.
module tb_fetch_unit_buffered;
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  fetch_unit_buffered_if #(.XLEN(64), .ILEN(32)) bus ();

  fetch_unit_buffered dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [63:0] addr; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] ins; logic mis; } exp_t;

  mreq_t pend[$];
  exp_t  exp_q[$];
  int    pop_cyc[$];
  int    lat = 1;
  int    budget_lim = 0;
  int    acc_cnt = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  assign bus.i_imem_req_ready = (acc_cnt < budget_lim);

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'hA500_0000 ^ a[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [63:0] pc);
    exp_q.push_back('{pc, instr_of(pc), 1'b0});
  endtask

  // Memory: samples the handshake at negedge, updates its drive just after the next posedge.
  initial begin : mem_model
    logic m_rst, m_acc, m_rsp;
    logic [63:0] m_addr;
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      m_rst  = !rst_n;
      m_acc  = bus.o_imem_req_valid && bus.i_imem_req_ready;
      m_addr = bus.o_imem_req_addr;
      m_rsp  = bus.i_imem_rsp_valid;
      @(posedge clk);
      #1;
      if (m_rst) begin
        pend.delete();
        acc_cnt = 0;
      end else begin
        if (m_rsp) void'(pend.pop_front());
        if (m_acc) begin
          pend.push_back('{cyc + lat - 1, m_addr});
          acc_cnt++;
        end
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_data  = instr_of(pend[0].addr);
      end else begin
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc=0x%0h, required no output (cycle %0d)", bus.o_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", bus.o_pc, e.pc);
            check("out_ins", 64'(bus.o_instruction), 64'(e.ins));
`ifdef FETCH_MISALIGN_TRAP_EN
            check("out_mis", 64'(bus.o_misaligned), 64'(e.mis));
`endif
          end
        end else if (!bus.o_valid) begin
          check("idle_pc", bus.o_pc, 64'h0);
          check("idle_ins", 64'(bus.o_instruction), 64'(NOP));
        end
      end
    end
  end

  task automatic do_reset(input int lat_v, input int bud_v, input logic rdy_v);
    rst_n = 1'b0;
    step();
    step();
    lat = lat_v;
    budget_lim = bud_v;
    bus.i_ready = rdy_v;
    exp_q.delete();
    pop_cyc.delete();
    @(negedge clk);
    check("rst_valid", 64'(bus.o_valid), 64'h0);
    check("rst_req_valid", 64'(bus.o_imem_req_valid), 64'h0);
    check("rst_pc", bus.o_pc, 64'h0);
    check("rst_ins", 64'(bus.o_instruction), 64'(NOP));
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'h0);
    repeat (5) step();
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = pc;
  endtask

  initial begin : stimulus
    int rel;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready       = 1'b0;

    // Streaming, latency 1, four requests allowed.
    do_reset(1, 4, 1'b1);
    rel = cyc;
    exp_push(64'h0); exp_push(64'h4); exp_push(64'h8); exp_push(64'hC);
    wait_drain("t1_drain", 50);
    if (pop_cyc.size() >= 4) begin
      check("t1_first_pop_cycle", 64'(pop_cyc[0] - rel), 64'd2);
      check("t1_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    end else begin
      check("t1_pop_count", 64'(pop_cyc.size()), 64'd4);
    end
    @(negedge clk);
    check("t1_next_req_valid", 64'(bus.o_imem_req_valid), 64'h1);
    check("t1_next_req_addr", bus.o_imem_req_addr, 64'h10);

    // Decode stalled: credit limits to four requests, head stays pc 0.
    do_reset(1, 5, 1'b0);
    exp_push(64'h0); exp_push(64'h4); exp_push(64'h8); exp_push(64'hC); exp_push(64'h10);
    repeat (10) step();
    check("t2_accepts_stalled", 64'(acc_cnt), 64'd4);
    @(negedge clk);
    check("t2_head_valid", 64'(bus.o_valid), 64'h1);
    check("t2_head_pc", bus.o_pc, 64'h0);
    step();
    bus.i_ready = 1'b1;
    wait_drain("t2_drain", 50);

    // Redirect with three outstanding, latency 4.
    do_reset(4, 3, 1'b1);
    repeat (3) step();
    redirect_to(64'h100);
    budget_lim = 5;
    exp_push(64'h100); exp_push(64'h104);
    @(negedge clk);
    check("t3_req_withdrawn", 64'(bus.o_imem_req_valid), 64'h0);
    step();
    bus.i_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_no_req_in_drain", 64'(bus.o_imem_req_valid), 64'h0);
      step();
    end
    @(negedge clk);
    check("t3_first_req_valid", 64'(bus.o_imem_req_valid), 64'h1);
    check("t3_first_req_addr", bus.o_imem_req_addr, 64'h100);
    step();
    wait_drain("t3_drain", 60);

    // Redirect coinciding with a response and a pop.
    do_reset(1, 4, 1'b1);
    repeat (2) step();
    redirect_to(64'h200);
    exp_push(64'h200); exp_push(64'h204);
    @(negedge clk);
    check("t4_pop_pending_valid", 64'(bus.o_valid), 64'h1);
    check("t4_pop_pending_pc", bus.o_pc, 64'h0);
    step();
    bus.i_redirect = 1'b0;
    wait_drain("t4_drain", 50);

    // Memory not ready: held address stays stable, redirect withdraws it.
    do_reset(1, 2, 1'b1);
    exp_push(64'h0); exp_push(64'h4);
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_held_valid", 64'(bus.o_imem_req_valid), 64'h1);
      check("t5_held_addr", bus.o_imem_req_addr, 64'h8);
      step();
    end
    redirect_to(64'h300);
    @(negedge clk);
    check("t5_withdrawn", 64'(bus.o_imem_req_valid), 64'h0);
    step();
    bus.i_redirect = 1'b0;
    budget_lim = 3;
    exp_push(64'h300);
    @(negedge clk);
    check("t5_new_valid", 64'(bus.o_imem_req_valid), 64'h1);
    check("t5_new_addr", bus.o_imem_req_addr, 64'h300);
    step();
    wait_drain("t5_drain", 50);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned target: one trap entry, then idle until the next redirect.
    do_reset(1, 4, 1'b1);
    redirect_to(64'h102);
    exp_q.push_back('{64'h102, NOP, 1'b1});
    step();
    bus.i_redirect = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_no_req_trap", 64'(bus.o_imem_req_valid), 64'h0);
      step();
    end
    check("t6_trap_seen", 64'(exp_q.size()), 64'h0);
    redirect_to(64'h400);
    exp_push(64'h400); exp_push(64'h404); exp_push(64'h408); exp_push(64'h40C);
    step();
    bus.i_redirect = 1'b0;
    wait_drain("t6_resume_drain", 50);
`else
    // Misaligned target: low bits are ignored.
    do_reset(1, 1, 1'b1);
    redirect_to(64'h302);
    exp_push(64'h300);
    step();
    bus.i_redirect = 1'b0;
    @(negedge clk);
    check("t6_aligned_addr", bus.o_imem_req_addr, 64'h300);
    step();
    wait_drain("t6_drain", 50);
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
